// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache request port among NUM_REQ requesters, one transaction in flight.
// Define CACHE_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module cache_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int PAYLOAD_W = 128,
    parameter int RESP_W    = 64,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           cache_req_valid,
    output logic [PAYLOAD_W-1:0]           cache_req_payload,
    input  logic                           cache_req_ready,
    input  logic                           cache_resp_valid,
    input  logic [RESP_W-1:0]              cache_resp_data,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [RESP_W-1:0]              resp_data,
    output logic                           busy,
    output logic [ID_W-1:0]                owner_id
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d;
    logic [ID_W-1:0]        owner_q, owner_d;
    logic [ID_W-1:0]        winner;
    logic [NUM_REQ-1:0]     masked;
    logic                   pickFound;

`ifndef CACHE_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]        last_q, last_d;

    // Only requesters strictly above the previous grant stay in the masked vector.
    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            masked[i] = req_valid[i] && (i > int'(last_q));
        end
    end
`else
    assign masked = '0;
`endif

    // Find-first-one on the masked vector, falling back to the raw request vector.
    always_comb begin
        winner    = '0;
        pickFound = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pickFound && masked[i]) begin
                winner    = ID_W'(i);
                pickFound = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pickFound && req_valid[i]) begin
                winner    = ID_W'(i);
                pickFound = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        payload_d  = payload_q;
        owner_d    = owner_q;
`ifndef CACHE_ARB_FIXED_PRIO_EN
        last_d     = last_q;
`endif
        req_ready  = '0;
        resp_valid = '0;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = NUM_REQ'(1) << winner;
                    payload_d = req_payload[int'(winner)*PAYLOAD_W +: PAYLOAD_W];
                    owner_d   = winner;
`ifndef CACHE_ARB_FIXED_PRIO_EN
                    last_d    = winner;
`endif
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (cache_req_ready) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (cache_resp_valid) begin
                    resp_valid = NUM_REQ'(1) << owner_q;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset points last at the top index so requester 0 wins the first arbitration.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            payload_q <= '0;
            owner_q   <= '0;
`ifndef CACHE_ARB_FIXED_PRIO_EN
            last_q    <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            owner_q   <= owner_d;
`ifndef CACHE_ARB_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
        end
    end

    assign cache_req_valid   = (state_q == ISSUE);
    assign cache_req_payload = payload_q;
    assign busy              = (state_q != IDLE);
    assign owner_id          = owner_q;
    assign resp_data         = cache_resp_data;

endmodule
